// File: rtl/game_over_ctrl.sv
// Match sequencer for the Pong toss game: runs the match timer, latches the result,
// drives the end-screen mux select and pulses the game-logic reset on (re)start.
module game_over_ctrl #(
  parameter int unsigned SCORE_W        = 4,
  parameter int unsigned WIN_SCORE      = 7,
  parameter int unsigned TIMER_W        = 12,
  parameter int unsigned MATCH_FRAMES   = 3600,
  parameter int unsigned HOLD_FRAMES    = 30,
  parameter int unsigned END_MIN_FRAMES = 120
) (
  input  logic               clk_d,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic [SCORE_W-1:0] score_p1,
  input  logic [SCORE_W-1:0] score_p2,
  output logic               play_en,
  output logic               end_screen_en,
  output logic               player1_win,
  output logic               player2_win,
  output logic               draw,
  output logic               game_reset,
  output logic [TIMER_W-1:0] frames_left
);

  localparam logic [SCORE_W-1:0] WinScore     = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] MatchFrames  = TIMER_W'(MATCH_FRAMES);
  localparam logic [TIMER_W-1:0] HoldFrames   = TIMER_W'(HOLD_FRAMES);
  localparam logic [TIMER_W-1:0] EndMinFrames = TIMER_W'(END_MIN_FRAMES);
  localparam logic [TIMER_W-1:0] One          = TIMER_W'(1);

  // StClear is the single game_reset cycle; end conditions are not evaluated there
  // because the score counters still hold the previous match until the pulse lands.
  typedef enum logic [2:0] {StIdle, StClear, StPlay, StHold, StEnd} state_e;

  state_e             state_q, state_d;
  logic               btn_q;
  logic [TIMER_W-1:0] cnt_q, cnt_d;
  logic [TIMER_W-1:0] frames_q, frames_d;
  logic               p1_win_q, p1_win_d;
  logic               p2_win_q, p2_win_d;
  logic               draw_q, draw_d;
  logic               play_en_q, play_en_d;
  logic               end_screen_q, end_screen_d;
  logic               game_reset_q, game_reset_d;

  logic press;
  logic score_end;
  logic time_end;

  assign press     = start_btn & ~btn_q;
  assign score_end = (score_p1 >= WinScore) || (score_p2 >= WinScore);
  assign time_end  = (frames_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    p1_win_d = p1_win_q;
    p2_win_d = p2_win_q;
    draw_d   = draw_q;

    unique case (state_q)
      StIdle: begin
        if (press) begin
          state_d  = StClear;
          frames_d = MatchFrames;
        end
      end
      StClear: begin
        state_d = StPlay;
      end
      StPlay: begin
        if (frame_tick && (frames_q != '0)) begin
          frames_d = frames_q - One;
        end
        // Score and timeout yield the same comparison, so priority is implicit.
        if (score_end || time_end) begin
          state_d  = StHold;
          cnt_d    = '0;
          p1_win_d = (score_p1 > score_p2);
          p2_win_d = (score_p2 > score_p1);
          draw_d   = (score_p1 == score_p2);
        end
      end
      StHold: begin
        if (cnt_q == HoldFrames) begin
          state_d = StEnd;
          cnt_d   = '0;
        end else if (frame_tick) begin
          cnt_d = cnt_q + One;
        end
      end
      StEnd: begin
        if (press && (cnt_q == EndMinFrames)) begin
          state_d  = StClear;
          cnt_d    = '0;
          frames_d = MatchFrames;
          p1_win_d = 1'b0;
          p2_win_d = 1'b0;
          draw_d   = 1'b0;
        end else if (frame_tick && (cnt_q != EndMinFrames)) begin
          cnt_d = cnt_q + One;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    play_en_d    = (state_d == StPlay) || (state_d == StClear);
    end_screen_d = (state_d == StEnd);
    game_reset_d = (state_d == StClear);
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      btn_q        <= 1'b1;
      cnt_q        <= '0;
      frames_q     <= MatchFrames;
      p1_win_q     <= 1'b0;
      p2_win_q     <= 1'b0;
      draw_q       <= 1'b0;
      play_en_q    <= 1'b0;
      end_screen_q <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      btn_q        <= start_btn;
      cnt_q        <= cnt_d;
      frames_q     <= frames_d;
      p1_win_q     <= p1_win_d;
      p2_win_q     <= p2_win_d;
      draw_q       <= draw_d;
      play_en_q    <= play_en_d;
      end_screen_q <= end_screen_d;
      game_reset_q <= game_reset_d;
    end
  end

  assign play_en       = play_en_q;
  assign end_screen_en = end_screen_q;
  assign player1_win   = p1_win_q;
  assign player2_win   = p2_win_q;
  assign draw          = draw_q;
  assign game_reset    = game_reset_q;
  assign frames_left   = frames_q;

endmodule
